// File: rtl/datapath_pipe_if.sv
// Issue/result bundle for datapath_pipe.
// The controller side drives ops and mdata; the datapath side returns ready, results and flags.
interface datapath_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [RW-1:0]    rd_a;
  logic [RW-1:0]    rd_b;
  logic [RW-1:0]    wr_num;
  logic             wr_en;
  logic [1:0]       alu_op;
  logic [1:0]       shift;
  logic             shift_ctrl;
  logic             asel;
  logic             bsel;
  logic [1:0]       vsel;
  logic             loads;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;
  logic [PCW-1:0]   pc;
  logic [WIDTH-1:0] mdata;
  logic             out_valid;
  logic [WIDTH-1:0] datapath_out;
  logic [2:0]       status_out;

  modport master (
    output in_valid, rd_a, rd_b, wr_num, wr_en, alu_op, shift, shift_ctrl,
           asel, bsel, vsel, loads, sximm5, sximm8, pc, mdata,
    input  in_ready, out_valid, datapath_out, status_out
  );

  modport slave (
    input  in_valid, rd_a, rd_b, wr_num, wr_en, alu_op, shift, shift_ctrl,
           asel, bsel, vsel, loads, sximm5, sximm8, pc, mdata,
    output in_ready, out_valid, datapath_out, status_out
  );
endinterface

// File: rtl/datapath_pipe.sv
// Three-stage (read / execute / writeback) register-file datapath with WB forwarding,
// EX-stage RAW stall, and {V,N,Z} status flags.
module datapath_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  datapath_pipe_if.slave dp_if
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef logic signed [WIDTH-1:0] word_t;

  function automatic word_t shift_b(input word_t b, input logic [1:0] sh);
    case (sh)
      2'b01:   return b <<< 1;
      2'b10:   return b >> 1;
      2'b11:   return b >>> 1;
      default: return b;
    endcase
  endfunction

  function automatic logic add_sub_ovf(input word_t a, input word_t b, input word_t r,
                                       input logic sub);
    logic b_msb;
    b_msb = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    return (a[WIDTH-1] == b_msb) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  word_t          regs_q [NREGS];

  // p1: execute stage
  logic           vld_p1_q;
  word_t          a_p1_q, b_p1_q, imm5_p1_q, imm8_p1_q;
  logic [RW-1:0]  wr_num_p1_q;
  logic           wr_en_p1_q, asel_p1_q, bsel_p1_q, loads_p1_q;
  logic [1:0]     alu_op_p1_q, shift_p1_q, vsel_p1_q;
  logic [PCW-1:0] pc_p1_q;

  // p2: writeback stage
  logic           vld_p2_q;
  word_t          c_p2_q, imm8_p2_q;
  logic [2:0]     status_q;
  logic [RW-1:0]  wr_num_p2_q;
  logic           wr_en_p2_q;
  logic [1:0]     vsel_p2_q;
  logic [PCW-1:0] pc_p2_q;

  word_t          wb_val, a_d, b_d, ain, bin, c_d;
  logic [2:0]     status_d;
  logic           ovf, wb_wr, hazard, fire;

  always_comb begin
    case (vsel_p2_q)
      2'b00:   wb_val = c_p2_q;
      2'b01:   wb_val = $signed(WIDTH'(pc_p2_q));
      2'b10:   wb_val = imm8_p2_q;
      default: wb_val = $signed(dp_if.mdata);
    endcase
  end

  // The WB write lands on the same edge as this read, so bypass the regfile.
  assign wb_wr = vld_p2_q && wr_en_p2_q;
  assign a_d   = (wb_wr && wr_num_p2_q == dp_if.rd_a) ? wb_val : regs_q[dp_if.rd_a];
  assign b_d   = (wb_wr && wr_num_p2_q == dp_if.rd_b) ? wb_val : regs_q[dp_if.rd_b];

  assign hazard = vld_p1_q && wr_en_p1_q &&
                  (wr_num_p1_q == dp_if.rd_a || wr_num_p1_q == dp_if.rd_b);
  assign fire   = dp_if.in_valid && !hazard;

  always_comb begin
    ain = asel_p1_q ? word_t'(0) : a_p1_q;
    bin = bsel_p1_q ? imm5_p1_q : shift_b(b_p1_q, shift_p1_q);
    ovf = 1'b0;
    case (alu_op_p1_q)
      2'b00: begin
        c_d = ain + bin;
        ovf = add_sub_ovf(ain, bin, c_d, 1'b0);
      end
      2'b01: begin
        c_d = ain - bin;
        ovf = add_sub_ovf(ain, bin, c_d, 1'b1);
      end
      2'b10:   c_d = ain & bin;
      default: c_d = ~bin;
    endcase
    status_d = {ovf, c_d[WIDTH-1], (c_d == word_t'(0))};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      a_p1_q      <= '0;
      b_p1_q      <= '0;
      imm5_p1_q   <= '0;
      imm8_p1_q   <= '0;
      wr_num_p1_q <= '0;
      wr_en_p1_q  <= 1'b0;
      asel_p1_q   <= 1'b0;
      bsel_p1_q   <= 1'b0;
      loads_p1_q  <= 1'b0;
      alu_op_p1_q <= '0;
      shift_p1_q  <= '0;
      vsel_p1_q   <= '0;
      pc_p1_q     <= '0;
      c_p2_q      <= '0;
      status_q    <= '0;
      imm8_p2_q   <= '0;
      wr_num_p2_q <= '0;
      wr_en_p2_q  <= 1'b0;
      vsel_p2_q   <= '0;
      pc_p2_q     <= '0;
    end else begin
      vld_p1_q <= fire;
      vld_p2_q <= vld_p1_q;
      if (fire) begin
        a_p1_q      <= a_d;
        b_p1_q      <= b_d;
        imm5_p1_q   <= dp_if.sximm5;
        imm8_p1_q   <= dp_if.sximm8;
        wr_num_p1_q <= dp_if.wr_num;
        wr_en_p1_q  <= dp_if.wr_en;
        asel_p1_q   <= dp_if.asel;
        bsel_p1_q   <= dp_if.bsel;
        loads_p1_q  <= dp_if.loads;
        alu_op_p1_q <= dp_if.alu_op;
        shift_p1_q  <= dp_if.shift_ctrl ? 2'b00 : dp_if.shift;
        vsel_p1_q   <= dp_if.vsel;
        pc_p1_q     <= dp_if.pc;
      end
      if (vld_p1_q) begin
        c_p2_q      <= c_d;
        if (loads_p1_q) status_q <= status_d;
        imm8_p2_q   <= imm8_p1_q;
        wr_num_p2_q <= wr_num_p1_q;
        wr_en_p2_q  <= wr_en_p1_q;
        vsel_p2_q   <= vsel_p1_q;
        pc_p2_q     <= pc_p1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_wr) begin
      regs_q[wr_num_p2_q] <= wb_val;
    end
  end

  assign dp_if.in_ready     = !hazard;
  assign dp_if.out_valid    = vld_p2_q;
  assign dp_if.datapath_out = c_p2_q;
  assign dp_if.status_out   = status_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed scenarios plus random op streams scored against
// a sequential-semantics architectural model (register array, status, output queue).
module tb_datapath_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  datapath_pipe_if #(.WIDTH(16), .NREGS(8), .PCW(8)) dif ();
  datapath_pipe #(.WIDTH(16), .NREGS(8), .PCW(8)) dut (.clk(clk), .rst_n(rst_n), .dp_if(dif));

  typedef struct packed {
    logic [2:0]  rd_a, rd_b, wr_num;
    logic        wr_en;
    logic [1:0]  alu_op, shift;
    logic        shift_ctrl, asel, bsel;
    logic [1:0]  vsel;
    logic        loads;
    logic [15:0] sximm5, sximm8;
    logic [7:0]  pc;
  } op_t;

  typedef struct {
    int          due;
    logic [15:0] c;
    logic [2:0]  st;
  } exp_t;

  int          mregs [8];
  logic [2:0]  mst;
  exp_t        q [$];
  int          last_acc = -10;
  logic        last_we = 1'b0;
  logic [2:0]  last_wn = '0;
  logic [15:0] last_c = '0;
  logic [2:0]  last_st = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cnt);
    end
  endtask

  function automatic logic [15:0] mdata_fn(input int c);
    logic [31:0] t;
    t = c * 32'd40503;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int to_s(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  // Architectural effect of one accepted op; called the cycle before its accept edge.
  task automatic model_accept(input op_t o);
    int a, b, r, sa, sb, sr, wbv;
    logic v;
    exp_t e;
    a = o.asel ? 0 : mregs[o.rd_a];
    b = mregs[o.rd_b];
    case (o.shift_ctrl ? 2'b00 : o.shift)
      2'b01:   b = (b * 2) % 65536;
      2'b10:   b = b / 2;
      2'b11:   b = b / 2 + ((b >= 32768) ? 32768 : 0);
      default: ;
    endcase
    if (o.bsel) b = int'(o.sximm5);
    sa = to_s(a);
    sb = to_s(b);
    v = 1'b0;
    case (o.alu_op)
      2'b00: begin r = (a + b) % 65536; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      2'b01: begin r = (a - b + 65536) % 65536; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      2'b10:   r = a & b;
      default: r = 65535 - b;
    endcase
    if (o.loads) mst = {v, (r >= 32768), (r == 0)};
    e.due = cnt + 2;
    e.c   = r[15:0];
    e.st  = mst;
    q.push_back(e);
    if (o.wr_en) begin
      case (o.vsel)
        2'b00:   wbv = r;
        2'b01:   wbv = int'(o.pc);
        2'b10:   wbv = int'(o.sximm8);
        default: wbv = int'(mdata_fn(cnt + 2));
      endcase
      mregs[o.wr_num] = wbv;
    end
    last_acc = cnt + 1;
    last_we  = o.wr_en;
    last_wn  = o.wr_num;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    mst = '0;
    q.delete();
    last_acc = -10;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic due;
      due = (q.size() > 0) && (q[0].due == cnt);
      check("out_valid", dif.out_valid, due);
      if (dif.out_valid) begin
        last_c  = dif.datapath_out;
        last_st = dif.status_out;
      end
      if (due) begin
        check("datapath_out", dif.datapath_out, q[0].c);
        check("status_out", dif.status_out, q[0].st);
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cnt) begin
        void'(q.pop_front());
      end
    end
  end

  initial begin
    dif.mdata = mdata_fn(0);
    forever begin
      @(posedge clk);
      #1 dif.mdata = mdata_fn(cnt);
    end
  end

  task automatic issue(input op_t o);
    int   tries;
    logic acc, exp_rdy;
    tries = 0;
    acc   = 1'b0;
    dif.rd_a = o.rd_a;  dif.rd_b = o.rd_b;  dif.wr_num = o.wr_num;  dif.wr_en = o.wr_en;
    dif.alu_op = o.alu_op;  dif.shift = o.shift;  dif.shift_ctrl = o.shift_ctrl;
    dif.asel = o.asel;  dif.bsel = o.bsel;  dif.vsel = o.vsel;  dif.loads = o.loads;
    dif.sximm5 = o.sximm5;  dif.sximm8 = o.sximm8;  dif.pc = o.pc;
    dif.in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      exp_rdy = !(last_acc == cnt && last_we && (last_wn == o.rd_a || last_wn == o.rd_b));
      check("in_ready", dif.in_ready, exp_rdy);
      if (dif.in_ready) begin
        acc = 1'b1;
      end else begin
        stall_cnt++;
        tries++;
        if (tries > 8) begin
          bad++;
          total++;
          $display("FAIL stall_timeout: stalled %0d cycles, allowed 8", tries);
          dif.in_valid = 1'b0;
          @(posedge clk);
          #1;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    model_accept(o);
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dif.in_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", dif.out_valid, 1'b0);
    check("rst_dout", dif.datapath_out, 16'h0);
    check("rst_status", dif.status_out, 3'b000);
    check("rst_in_ready", dif.in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic op_t w_imm(input logic [2:0] r, input logic [15:0] v);
    op_t o;
    o = '0;
    o.wr_en = 1'b1;  o.wr_num = r;  o.vsel = 2'b10;  o.sximm8 = v;
    o.asel = 1'b1;   o.bsel = 1'b1;
    return o;
  endfunction

  function automatic op_t alu(input logic [1:0] op, input logic [2:0] wr, input logic [2:0] ra,
                              input logic [2:0] rb, input logic ld);
    op_t o;
    o = '0;
    o.alu_op = op;  o.wr_en = 1'b1;  o.wr_num = wr;  o.rd_a = ra;  o.rd_b = rb;  o.loads = ld;
    return o;
  endfunction

  function automatic op_t rd(input logic [2:0] r);
    op_t o;
    o = '0;
    o.asel = 1'b1;  o.rd_a = r;  o.rd_b = r;
    return o;
  endfunction

  initial begin
    op_t o;
    dif.in_valid = 1'b0;
    issue_defaults: begin
      dif.rd_a = '0; dif.rd_b = '0; dif.wr_num = '0; dif.wr_en = 1'b0; dif.alu_op = '0;
      dif.shift = '0; dif.shift_ctrl = 1'b0; dif.asel = 1'b0; dif.bsel = 1'b0;
      dif.vsel = '0; dif.loads = 1'b0; dif.sximm5 = '0; dif.sximm8 = '0; dif.pc = '0;
    end
    do_reset();

    for (int r = 0; r < 8; r++) begin
      issue(rd(3'(r)));
      drain();
      check("reset_reg", last_c, 16'h0);
    end

    issue(w_imm(3'd1, 16'h0005));
    issue(alu(2'b00, 3'd2, 3'd1, 3'd1, 1'b0));
    drain();
    check("r2_eq_r1_plus_r1", last_c, 16'h000A);

    issue(alu(2'b00, 3'd3, 3'd1, 3'd1, 1'b0));
    stall_cnt = 0;
    issue(alu(2'b00, 3'd4, 3'd3, 3'd0, 1'b0));
    check("raw_stall_cycles", stall_cnt, 1);
    drain();
    issue(rd(3'd4));
    drain();
    check("r4_value", last_c, 16'h000A);

    issue(w_imm(3'd1, 16'h7FFF));
    issue(w_imm(3'd2, 16'h0001));
    drain();
    issue(alu(2'b00, 3'd3, 3'd1, 3'd2, 1'b1));
    drain();
    check("ovf_c", last_c, 16'h8000);
    check("ovf_status", last_st, 3'b110);
    issue(w_imm(3'd5, 16'h0003));
    drain();
    issue(alu(2'b01, 3'd6, 3'd5, 3'd5, 1'b1));
    drain();
    check("sub_zero_c", last_c, 16'h0000);
    check("sub_zero_status", last_st, 3'b001);

    issue(w_imm(3'd7, 16'h8002));
    drain();
    o = rd(3'd7);
    o.shift = 2'b11;
    issue(o);
    drain();
    check("asr1_bin", last_c, 16'hC001);
    o.shift_ctrl = 1'b1;
    issue(o);
    drain();
    check("shift_ctrl_bin", last_c, 16'h8002);

    issue(w_imm(3'd5, 16'h1234));
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_pulse", dif.out_valid, 1'b0);
    drain();
    issue(rd(3'd5));
    drain();
    check("midrst_r5", last_c, 16'h0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      o = op_t'({$urandom, $urandom, $urandom});
      issue(o);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    for (int r = 0; r < 8; r++) issue(rd(3'(r)));
    drain();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
